// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage buffers of the 16-bit five-stage core:
// occupancy states and the NOP control word used at each stage boundary.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    // Control bus layout: {SendNOP, write_reg[2:0], RegSrc[1:0], MemWrt, RegWrt}
    localparam int REG_WRT_BIT   = 0;
    localparam int MEM_WRT_BIT   = 1;
    localparam int REG_SRC_LSB   = 2;
    localparam int WRITE_REG_LSB = 4;
    localparam int SEND_NOP_BIT  = 7;

    function automatic logic [7:0] make_ctrl(
        input logic       send_nop,
        input logic [2:0] write_reg,
        input logic [1:0] reg_src,
        input logic       mem_wrt,
        input logic       reg_wrt
    );
        return {send_nop, write_reg, reg_src, mem_wrt, reg_wrt};
    endfunction

    localparam logic [7:0] IF_ID_NOP_CTRL  = make_ctrl(1'b1, 3'd0, 2'd0, 1'b0, 1'b0);
    localparam logic [7:0] ID_EX_NOP_CTRL  = make_ctrl(1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    localparam logic [7:0] EX_MEM_NOP_CTRL = make_ctrl(1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    localparam logic [7:0] MEM_WB_NOP_CTRL = make_ctrl(1'b0, 3'd0, 2'd0, 1'b0, 1'b0);

endpackage

// File: rtl/dff.sv
// Generic register cell with synchronous reset value and load enable.
module dff #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Register with reset priority over load
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_r;

    // Count up until all-ones, then hold
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_r <= {W{1'b0}};
        end else if (inc && (cnt_r != {W{1'b1}})) begin
            cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: main register feeds the outputs, a skid register absorbs one
// transfer while downstream stalls so in_ready can be registered; flush turns entries into bubbles.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                PAYLOAD_W = 16,
    parameter int                CTRL_W    = 8,
    parameter logic [CTRL_W-1:0] NOP_CTRL  = '0,
    parameter int                CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [CTRL_W-1:0]    in_ctrl,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [CTRL_W-1:0]    out_ctrl,
    input  logic                 flush,
    input  logic                 clr_cnt,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    pipe_state_t          state_r, state_nxt_s;
    logic                 in_ready_r, out_valid_r;
    logic                 accept_s, emit_s;
    logic                 main_from_in_s, main_from_skid_s, skid_load_s, going_empty_s;
    logic                 main_pay_en_s, main_ctrl_en_s;
    logic [PAYLOAD_W-1:0] main_pay_d_s, main_pay_r, skid_pay_r;
    logic [CTRL_W-1:0]    main_ctrl_d_s, main_ctrl_r, skid_ctrl_r;

    assign accept_s = in_valid & in_ready_r;
    assign emit_s   = out_valid_r & out_ready;

    // State register; handshake flags are registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s != TWO);
            out_valid_r <= (state_nxt_s != EMPTY);
        end
    end

    // Next-state logic; flush overrides every transfer
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: state_nxt_s = accept_s ? ONE : EMPTY;
                ONE: begin
                    if (accept_s && !emit_s) begin
                        state_nxt_s = TWO;
                    end else if (!accept_s && emit_s) begin
                        state_nxt_s = EMPTY;
                    end else begin
                        state_nxt_s = ONE;
                    end
                end
                TWO:     state_nxt_s = emit_s ? ONE : TWO;
                default: state_nxt_s = EMPTY;
            endcase
        end
    end

    // Datapath load controls; control word becomes NOP whenever the stage drains
    always_comb begin
        main_from_in_s   = !flush && accept_s &&
                           ((state_r == EMPTY) || ((state_r == ONE) && emit_s));
        main_from_skid_s = !flush && (state_r == TWO) && emit_s;
        skid_load_s      = !flush && (state_r == ONE) && accept_s && !emit_s;
        going_empty_s    = (state_nxt_s == EMPTY);
        main_pay_en_s    = main_from_in_s || main_from_skid_s;
        main_ctrl_en_s   = main_pay_en_s || going_empty_s;
        main_pay_d_s     = main_from_skid_s ? skid_pay_r : in_payload;
        if (going_empty_s) begin
            main_ctrl_d_s = NOP_CTRL;
        end else if (main_from_skid_s) begin
            main_ctrl_d_s = skid_ctrl_r;
        end else begin
            main_ctrl_d_s = in_ctrl;
        end
    end

    dff #(.W(PAYLOAD_W), .RST_VAL({PAYLOAD_W{1'b0}})) u_main_pay (
        .clk(clk), .rst(rst), .en(main_pay_en_s), .d(main_pay_d_s), .q(main_pay_r)
    );
    dff #(.W(CTRL_W), .RST_VAL(NOP_CTRL)) u_main_ctrl (
        .clk(clk), .rst(rst), .en(main_ctrl_en_s), .d(main_ctrl_d_s), .q(main_ctrl_r)
    );
    dff #(.W(PAYLOAD_W), .RST_VAL({PAYLOAD_W{1'b0}})) u_skid_pay (
        .clk(clk), .rst(rst), .en(skid_load_s), .d(in_payload), .q(skid_pay_r)
    );
    dff #(.W(CTRL_W), .RST_VAL({CTRL_W{1'b0}})) u_skid_ctrl (
        .clk(clk), .rst(rst), .en(skid_load_s), .d(in_ctrl), .q(skid_ctrl_r)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst(rst), .inc(out_valid_r & ~out_ready), .clr(clr_cnt), .cnt(stall_cnt)
    );
    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk(clk), .rst(rst), .inc(~out_valid_r), .clr(clr_cnt), .cnt(bubble_cnt)
    );

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_payload = main_pay_r;
    assign out_ctrl    = main_ctrl_r;

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised elastic pipeline stage for the 16-bit five-stage core: the next-generation replacement for the fixed inter-stage flop banks (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries one payload bus and one control bus between stages with a valid/ready handshake, a two-entry skid so that `in_ready` is registered, a flush that converts in-flight instructions into bubbles, and saturating stall/bubble counters for performance debug. Control seen downstream on a bubble is forced to a NOP encoding so that no `RegWrt`/`MemWrt` can leak.

## Interface
- `PAYLOAD_W`, 16: width of the data bus (ALU result, PC, B input, memory data, etc. concatenated by the instantiating stage).
- `CTRL_W`, 8: width of the control bus (RegSrc, RegWrt, write_reg, SendNOP, ...).
- `NOP_CTRL`, `'0`: value driven on `out_ctrl` whenever `out_valid`=0; must encode RegWrt=0 and MemWrt=0.
- `CNT_W`, 16: width of each performance counter.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream stage holds a valid instruction.
- `in_ready`  out  1  stage can accept; registered, not a function of `out_ready`.
- `in_payload`  in  PAYLOAD_W  upstream data.
- `in_ctrl`  in  CTRL_W  upstream control.
- `out_valid`  out  1  downstream sees a valid instruction.
- `out_ready`  in  1  downstream accepts (0 = downstream stall).
- `out_payload`  out  PAYLOAD_W  data to next stage.
- `out_ctrl`  out  CTRL_W  control to next stage; `NOP_CTRL` when `out_valid`=0.
- `flush`  in  1  discard every entry held and the entry offered this cycle.
- `clr_cnt`  in  1  zero both counters.
- `stall_cnt`  out  CNT_W  cycles with `out_valid`=1 and `out_ready`=0.
- `bubble_cnt`  out  CNT_W  cycles with `out_valid`=0.

## Operation
- Storage: the main register drives the outputs, and the skid register catches one transfer while the main register is blocked.
- States: EMPTY (0 entries), ONE (main only), TWO (main + skid).
- Transfer events: accept = `in_valid & in_ready`; emit = `out_valid & out_ready`.
- Transitions without flush:
  - EMPTY: accept → ONE, and main loads the input.
  - ONE: accept & emit → ONE, and main reloads from the input. Accept with no emit → TWO, and skid loads the input. Emit with no accept → EMPTY.
  - TWO: emit → ONE, and main loads from skid. No emit → hold. No accept is possible in TWO.
- `in_ready` = 1 in EMPTY or ONE, 0 in TWO. This value is registered from the next state.
- `flush`=1 forces the next state to EMPTY regardless of other inputs; the offered input is dropped and `in_ready` becomes 1.
- `flush` takes priority over accept, emit and skid promotion.
- Order is strictly FIFO; no entry is duplicated or lost except by flush.
- `out_payload` holds its last value when invalid; it is not zeroed (a don't-care for verification).
- `out_ctrl` is muxed to `NOP_CTRL` when invalid.
- Counters saturate at all-ones and never wrap.
  - `stall_cnt` increments on each cycle with `out_valid & ~out_ready`.
  - `bubble_cnt` increments on each cycle with `~out_valid`.
  - `clr_cnt` zeroes both counters next cycle and has priority over increment.
  - Counters are not affected by `flush`.

## Timing
- Reset values: state EMPTY, `in_ready`=1, `out_valid`=0, `out_ctrl`=`NOP_CTRL`, `out_payload`=0, skid=0, both counters 0.
- `rst` asserted mid-operation discards all entries at that edge, identically to reset from idle.
- Latency: an input accepted at edge k appears on the outputs after edge k (1 cycle). Throughput is 1 per cycle with `out_ready` held high.
- A downstream stall of N cycles followed by release loses nothing.
- Flush asserted at edge k: `out_valid`=0 after edge k. A new accept is possible at edge k+1.
- Flush and reset in the same cycle: reset wins; the result is identical.
- A counter at saturation stays at saturation.

## Structure
- Shared package `pipe_pkg` holds:
  - the state enum `pipe_state_t` {EMPTY, ONE, TWO};
  - the default NOP control constant for each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB), built from the core's RegSrc/RegWrt/write_reg field layout.
- Sub-module `sat_counter` (parameter `W`; ports `clk`, `rst`, `inc`, `clr`, `cnt`) is instantiated twice.
- Payload and control are registered with the codebase `dff` cell arrays with enables; next-state logic is a separate combinational block.

## Test plan
- Stream 10 entries with `out_ready`=1 and payloads 0x0001..0x000A → outputs appear one cycle later in order, and `in_ready` stays 1 throughout.
- Accept 0x1234, then hold `out_ready`=0 while offering 0x5678 and 0x9ABC:
  - 0x5678 goes to skid and `in_ready`=0, so 0x9ABC is not accepted.
  - On release, outputs are 0x1234 then 0x5678.
  - `stall_cnt` equals the number of stalled cycles.
- In TWO, assert `flush` with `in_valid`=1 → next cycle `out_valid`=0, `out_ctrl`=`NOP_CTRL`, `in_ready`=1; neither held entry ever emerges.
- Assert `rst` during a stalled TWO state → all outputs return to reset values next cycle, and `bubble_cnt` restarts from 0.
- `CNT_W`=4 with 20 idle cycles → `bubble_cnt` stops at 15. Then `clr_cnt` together with an idle cycle → 0 next cycle.
- `in_ctrl` with RegWrt=1 is blocked by flush → no cycle shows RegWrt=1 with `out_valid`=0.
